// File: rtl/nibble_seq_pkg.sv
// Shared constants, FSM encoding and saturation helpers for the nibble-serial adder.
package nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Clamp patterns for a w-bit signed result, returned in a 64-bit container.
  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand request / result handshake bundle between the ALU front-end and the serial adder.
interface nibble_serial_adder_ctrl_if
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start_valid, a, b, sub, res_ready,
    input  start_ready, res_valid, sum, cout, ovf
  );

  modport slave (
    input  start_valid, a, b, sub, res_ready,
    output start_ready, res_valid, sum, cout, ovf
  );
endinterface

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple carry adder; Cin_msb is the carry into bit 3 for signed overflow detection.
module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout,
  output logic       Cin_msb
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | ((A[i] ^ B[i]) & c[i]);
    end
  end

  assign Cout    = c[4];
  assign Cin_msb = c[3];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequenced LS nibble first over one 4-bit adder.
// Optional signed saturation of the final result: define NIBBLE_SEQ_SAT_EN.
module nibble_serial_adder_ctrl
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                       clk,
  input logic                       rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic [W-1:0]       sum_r;
  logic [W-1:0]       sum_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               cout_r;
  logic               ovf_r;
  logic [NIBBLE_W-1:0] add_a;
  logic [NIBBLE_W-1:0] add_b;
  logic [NIBBLE_W-1:0] add_s;
  logic               add_cout;
  logic               add_cin_msb;
  logic               ovf_next;
  logic               accept;

`ifdef NIBBLE_SEQ_SAT_EN
  localparam logic [63:0] SAT_POS = sat_pos(W);
  localparam logic [63:0] SAT_NEG = sat_neg(W);

  // Overflow can only occur when both effective operands share a sign, so op_a's sign is the true sign.
  function automatic logic [W-1:0] saturate(input logic neg);
    return neg ? SAT_NEG[W-1:0] : SAT_POS[W-1:0];
  endfunction
`endif

  assign add_a    = op_a[{idx, 2'b00} +: NIBBLE_W];
  assign add_b    = op_b[{idx, 2'b00} +: NIBBLE_W];
  assign ovf_next = add_cout ^ add_cin_msb;
  assign accept   = (state == ST_IDLE) && bus.start_valid;

  ripple_carry_adder u_rca (
    .A       (add_a),
    .B       (add_b),
    .Cin     (carry),
    .S       (add_s),
    .Cout    (add_cout),
    .Cin_msb (add_cin_msb)
  );

  always_comb begin
    sum_next = sum_r;
    sum_next[{idx, 2'b00} +: NIBBLE_W] = add_s;
`ifdef NIBBLE_SEQ_SAT_EN
    if (idx == LAST && ovf_next) sum_next = saturate(op_a[W-1]);
`endif
  end

  // Operand capture: subtraction is folded into inverted B plus carry-in of 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= bus.a;
      op_b <= bus.sub ? ~bus.b : bus.b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            state <= ST_RUN;
            idx   <= '0;
            carry <= bus.sub;
          end
        end
        ST_RUN: begin
          sum_r <= sum_next;
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_r <= add_cout;
            ovf_r  <= ovf_next;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == ST_IDLE);
  assign bus.res_valid   = (state == ST_DONE);
  assign bus.sum         = sum_r;
  assign bus.cout        = cout_r;
  assign bus.ovf         = ovf_r;
endmodule
